// File: rtl/game_pkg.sv
// Shared types and constants for the round sequencer.
//   round_state_t : FSM state encoding (IDLE=0 ... GAME_OVER=7), also driven on o_state.
//   STATE_W       : width of the state encoding.
//   LIVES_W       : width of the lives counter.
//   cnt_w()       : counter width for a terminal count, never below one bit.
package game_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LIVES_W = 4;

  typedef enum logic [STATE_W-1:0] {
    StIdle,
    StGen,
    StWaitRdy,
    StPlay,
    StPaused,
    StWinShow,
    StLoseShow,
    StGameOver
  } round_state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one history flop, combinational pulse while the input
// is high for the first cycle after a 0->1 transition.
//   clk     : system clock
//   arst    : asynchronous active-high reset (history cleared)
//   i_level : debounced button level
//   o_rise  : rising-edge pulse
module edge_detect (
  input  logic clk,
  input  logic arst,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: start/level-generate/play/pause/result/game-over flow,
// with rating and lives bookkeeping. All outputs are registered.
// Optional feature: define ROUND_SEQUENCER_RDY_TIMEOUT_EN to re-strobe level
// generation when i_safe_zone_rdy does not arrive within RDY_TIMEOUT cycles.
// Ports:
//   clk, arst            : clock, asynchronous active-high reset
//   i_start, i_pause_btn : debounced button levels (edge detected here)
//   i_safe_zone_rdy      : level generation finished
//   i_win, i_lose        : round outcome
//   o_regenerate_level   : one-cycle new-level strobe
//   o_pause              : freeze ball/timer (low only while playing)
//   o_rating, o_lives    : score and remaining lives
//   o_game_over          : game-over indicator
//   o_state              : encoded FSM state
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned RATING_WIDTH       = 8,
  parameter int unsigned NUM_LIVES          = 3,
  parameter int unsigned RESULT_HOLD_CYCLES = 72_000_000,
  parameter int unsigned RDY_TIMEOUT        = 1_000_000
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    i_start,
  input  logic                    i_pause_btn,
  input  logic                    i_safe_zone_rdy,
  input  logic                    i_win,
  input  logic                    i_lose,
  output logic                    o_regenerate_level,
  output logic                    o_pause,
  output logic [RATING_WIDTH-1:0] o_rating,
  output logic [LIVES_W-1:0]      o_lives,
  output logic                    o_game_over,
  output logic [STATE_W-1:0]      o_state
);

  localparam int unsigned HOLD_W = cnt_w(RESULT_HOLD_CYCLES);

  round_state_t            r_state, w_state_d;
  logic [RATING_WIDTH-1:0] r_rating, w_rating_d;
  logic [LIVES_W-1:0]      r_lives, w_lives_d;
  logic [HOLD_W-1:0]       r_hold_cnt, w_hold_cnt_d;
  logic                    r_regen, w_regen_d;
  logic                    r_pause, w_pause_d;
  logic                    r_game_over, w_game_over_d;
  // Blocks presses on the first cycle after reset so a held button is not a press.
  logic                    r_armed;
  logic                    w_start_rise, w_pause_rise;
  logic                    w_start_press, w_pause_press;
  logic                    w_hold_done;
  logic                    w_rdy_expired;

  edge_detect u_start_edge (
    .clk     (clk),
    .arst    (arst),
    .i_level (i_start),
    .o_rise  (w_start_rise)
  );

  edge_detect u_pause_edge (
    .clk     (clk),
    .arst    (arst),
    .i_level (i_pause_btn),
    .o_rise  (w_pause_rise)
  );

  assign w_start_press = w_start_rise & r_armed;
  assign w_pause_press = w_pause_rise & r_armed;
  assign w_hold_done   = (r_hold_cnt == HOLD_W'(RESULT_HOLD_CYCLES - 1));

`ifdef ROUND_SEQUENCER_RDY_TIMEOUT_EN
  localparam int unsigned RDY_W = cnt_w(RDY_TIMEOUT);

  logic [RDY_W-1:0] r_rdy_cnt, w_rdy_cnt_d;

  assign w_rdy_expired = (r_rdy_cnt == RDY_W'(RDY_TIMEOUT - 1));

  always_comb begin
    w_rdy_cnt_d = '0;
    if (r_state == StWaitRdy && w_state_d == StWaitRdy) begin
      w_rdy_cnt_d = r_rdy_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_rdy_cnt <= '0;
    end else begin
      r_rdy_cnt <= w_rdy_cnt_d;
    end
  end
`else
  assign w_rdy_expired = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= StIdle;
      r_rating    <= '0;
      r_lives     <= LIVES_W'(NUM_LIVES);
      r_hold_cnt  <= '0;
      r_regen     <= 1'b0;
      r_pause     <= 1'b1;
      r_game_over <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rating    <= w_rating_d;
      r_lives     <= w_lives_d;
      r_hold_cnt  <= w_hold_cnt_d;
      r_regen     <= w_regen_d;
      r_pause     <= w_pause_d;
      r_game_over <= w_game_over_d;
      r_armed     <= 1'b1;
    end
  end

  // Next state and score bookkeeping.
  always_comb begin
    w_state_d  = r_state;
    w_rating_d = r_rating;
    w_lives_d  = r_lives;
    case (r_state)
      StIdle: begin
        if (w_start_press) w_state_d = StGen;
      end
      StGen: begin
        w_state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (i_safe_zone_rdy) begin
          w_state_d = StPlay;
        end else if (w_rdy_expired) begin
          w_state_d = StGen;
        end
      end
      StPlay: begin
        // Win beats lose, and any result beats a pause press.
        if (i_win) begin
          w_state_d = StWinShow;
          if (r_rating != '1) w_rating_d = r_rating + 1'b1;
        end else if (i_lose) begin
          w_lives_d = r_lives - 1'b1;
          w_state_d = (w_lives_d == '0) ? StGameOver : StLoseShow;
        end else if (w_pause_press) begin
          w_state_d = StPaused;
        end
      end
      StPaused: begin
        if (w_pause_press) w_state_d = StPlay;
      end
      StWinShow, StLoseShow: begin
        if (w_hold_done) w_state_d = StGen;
      end
      StGameOver: begin
        if (w_start_press) begin
          w_rating_d = '0;
          w_lives_d  = LIVES_W'(NUM_LIVES);
          w_state_d  = StGen;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Next values of the registered outputs and the result-hold counter.
  always_comb begin
    w_regen_d     = (w_state_d == StGen);
    w_pause_d     = (w_state_d != StPlay);
    w_game_over_d = (w_state_d == StGameOver);
    w_hold_cnt_d  = '0;
    if ((r_state == StWinShow || r_state == StLoseShow) && w_state_d == r_state) begin
      w_hold_cnt_d = r_hold_cnt + 1'b1;
    end
  end

  assign o_regenerate_level = r_regen;
  assign o_pause            = r_pause;
  assign o_rating           = r_rating;
  assign o_lives            = r_lives;
  assign o_game_over        = r_game_over;
  assign o_state            = r_state;

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

  localparam int RW   = 2;
  localparam int NL   = 2;
  localparam int HOLD = 4;
  localparam int TO   = 8;
`ifdef ROUND_SEQUENCER_RDY_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam int S_IDLE = 0, S_GEN = 1, S_WAIT = 2, S_PLAY = 3;
  localparam int S_PAUSED = 4, S_WIN = 5, S_LOSE = 6, S_OVER = 7;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic start = 1'b0, pbtn = 1'b0, rdy = 1'b0, win = 1'b0, lose = 1'b0;
  logic          regen, pause, go;
  logic [RW-1:0] rating;
  logic [3:0]    lives;
  logic [2:0]    state;

  always #5 clk = ~clk;

  round_sequencer #(
    .RATING_WIDTH       (RW),
    .NUM_LIVES          (NL),
    .RESULT_HOLD_CYCLES (HOLD),
    .RDY_TIMEOUT        (TO)
  ) dut (
    .clk                (clk),
    .arst               (arst),
    .i_start            (start),
    .i_pause_btn        (pbtn),
    .i_safe_zone_rdy    (rdy),
    .i_win              (win),
    .i_lose             (lose),
    .o_regenerate_level (regen),
    .o_pause            (pause),
    .o_rating           (rating),
    .o_lives            (lives),
    .o_game_over        (go),
    .o_state            (state)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: game phase, cycles spent in that phase, score, button history.
  int m_state, m_t, m_rating, m_lives;
  bit m_prev_s, m_prev_p, m_armed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = S_IDLE;
    m_t      = 0;
    m_rating = 0;
    m_lives  = NL;
    m_prev_s = 1'b0;
    m_prev_p = 1'b0;
    m_armed  = 1'b0;
  endtask

  task automatic model_step();
    bit sp, pp;
    int nxt;
    sp = m_armed && start && !m_prev_s;
    pp = m_armed && pbtn && !m_prev_p;
    m_prev_s = start;
    m_prev_p = pbtn;
    m_armed  = 1'b1;
    m_t++;
    nxt = m_state;
    case (m_state)
      S_IDLE:   if (sp) nxt = S_GEN;
      S_GEN:    nxt = S_WAIT;
      S_WAIT:   if (rdy) nxt = S_PLAY; else if (TIMEOUT_ON && m_t == TO) nxt = S_GEN;
      S_PLAY: begin
        if (win) begin
          nxt = S_WIN;
          if (m_rating < (1 << RW) - 1) m_rating++;
        end else if (lose) begin
          m_lives--;
          nxt = (m_lives == 0) ? S_OVER : S_LOSE;
        end else if (pp) begin
          nxt = S_PAUSED;
        end
      end
      S_PAUSED: if (pp) nxt = S_PLAY;
      S_WIN, S_LOSE: if (m_t == HOLD) nxt = S_GEN;
      S_OVER: begin
        if (sp) begin
          m_rating = 0;
          m_lives  = NL;
          nxt      = S_GEN;
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (nxt != m_state) m_t = 0;
    m_state = nxt;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state));
    chk("regen", 32'(regen), 32'(m_state == S_GEN));
    chk("pause", 32'(pause), 32'(m_state != S_PLAY));
    chk("game_over", 32'(go), 32'(m_state == S_OVER));
    chk("rating", 32'(rating), 32'(m_rating));
    chk("lives", 32'(lives), 32'(m_lives));
  end

  task automatic tick();
    @(posedge clk);
    if (!arst) model_step();
    #1;
  endtask

  task automatic goto_play();
    int n;
    n = 0;
    if (m_state == S_IDLE || m_state == S_OVER) begin
      start = 1'b1; tick(); start = 1'b0;
    end
    rdy = 1'b1;
    while (m_state != S_PLAY && n < 40) begin
      tick();
      n++;
    end
    rdy = 1'b0;
    chk("goto_play_bound", 32'(m_state), 32'(S_PLAY));
  endtask

  task automatic do_reset();
    arst = 1'b1;
    model_reset();
    #2;
    chk("rst_regen", 32'(regen), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(posedge clk);
    #1 arst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_state", 32'(state), 32'd0);
    chk("lit_rst_pause", 32'(pause), 32'd1);
    chk("lit_rst_lives", 32'(lives), 32'd2);
    chk("lit_rst_rating", 32'(rating), 32'd0);
    arst = 1'b0;

    // Start press seen at cycle 5 -> strobe visible for exactly one cycle.
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("lit_gen_regen", 32'(regen), 32'd1);
    chk("lit_gen_pause", 32'(pause), 32'd1);
    tick();
    chk("lit_wait_regen", 32'(regen), 32'd0);
    chk("lit_wait_state", 32'(state), 32'd2);
    repeat (20) tick();
    goto_play();
    chk("lit_play_pause", 32'(pause), 32'd0);

    // Win: rating 0->1, four held cycles, then one strobe.
    win = 1'b1; tick(); win = 1'b0;
    chk("lit_win_rating", 32'(rating), 32'd1);
    chk("lit_win_state", 32'(state), 32'd5);
    repeat (3) tick();
    chk("lit_win_hold", 32'(pause), 32'd1);
    chk("lit_win_hold_state", 32'(state), 32'd5);
    tick();
    chk("lit_win_regen", 32'(regen), 32'd1);

    // Two losses -> game over, then restart.
    goto_play();
    lose = 1'b1; tick(); lose = 1'b0;
    chk("lit_lose1_lives", 32'(lives), 32'd1);
    chk("lit_lose1_state", 32'(state), 32'd6);
    goto_play();
    lose = 1'b1; tick(); lose = 1'b0;
    chk("lit_lose2_lives", 32'(lives), 32'd0);
    chk("lit_over", 32'(go), 32'd1);
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("lit_restart_rating", 32'(rating), 32'd0);
    chk("lit_restart_lives", 32'(lives), 32'd2);
    chk("lit_restart_regen", 32'(regen), 32'd1);

    // Pause held 10 cycles toggles once; win while paused is ignored.
    goto_play();
    pbtn = 1'b1; repeat (10) tick();
    chk("lit_paused", 32'(state), 32'd4);
    win = 1'b1; tick(); win = 1'b0;
    chk("lit_paused_win", 32'(state), 32'd4);
    pbtn = 1'b0; tick();
    pbtn = 1'b1; tick(); pbtn = 1'b0;
    chk("lit_unpaused", 32'(state), 32'd3);

    // Rating saturates at 3; simultaneous win/lose is a win.
    for (int i = 0; i < 4; i++) begin
      goto_play();
      win = 1'b1; tick(); win = 1'b0;
    end
    chk("lit_sat", 32'(rating), 32'd3);
    goto_play();
    win = 1'b1; lose = 1'b1; tick(); win = 1'b0; lose = 1'b0;
    chk("lit_winlose_state", 32'(state), 32'd5);
    chk("lit_winlose_lives", 32'(lives), 32'd2);

    // Result beats a coincident pause press.
    goto_play();
    pbtn = 1'b1; lose = 1'b1; tick(); pbtn = 1'b0; lose = 1'b0;
    chk("lit_lose_vs_pause", 32'(state), 32'd6);

    // Reset mid-round with start held: no strobe, no press after release.
    start = 1'b1;
    do_reset();
    repeat (5) tick();
    chk("lit_held_start", 32'(state), 32'd0);
    start = 1'b0;

    // Randomized play.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) pbtn = ~pbtn;
      rdy  = ($urandom_range(0, 5) == 0);
      win  = ($urandom_range(0, 14) == 0);
      lose = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
    end

    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
